// File: rtl/prio_dispatch_pkg.sv
// Purpose: shared types and defaults for the priority dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prio_dispatch_pkg;

  // Default number of request lines; must be a power of two, >= 2.
  localparam int DEFAULT_N = 4;

  // Dispatcher FSM: IDLE looks for work, GRANT holds one grant until ack.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_dispatch_if.sv
// Purpose: request/grant bundle between encoder-side driver and dispatcher.
// Latency: n/a (wires only).
// Backpressure: grant is held by the dispatcher until the consumer raises ack.
// Ports: in/in_valid (encoded request), ack (grant accept), overrun_clr,
//        out/out_valid (one-hot grant), pending (request bitmap), overrun.
interface prio_dispatch_if
  import prio_dispatch_pkg::*;
#(
  parameter int N = DEFAULT_N
);
  localparam int W = $clog2(N);

  logic [W-1:0] in;
  logic         in_valid;
  logic         ack;
  logic         overrun_clr;
  logic [N-1:0] out;
  logic         out_valid;
  logic [N-1:0] pending;
  logic         overrun;

  // master: encoder / consumer side, slave: the dispatcher itself.
  modport master (
    output in, in_valid, ack, overrun_clr,
    input  out, out_valid, pending, overrun
  );

  modport slave (
    input  in, in_valid, ack, overrun_clr,
    output out, out_valid, pending, overrun
  );

endinterface

// File: rtl/prio_pick.sv
// Purpose: highest-set-bit finder, MSB wins (mirror of the upstream encoder).
// Latency: combinational.
// Backpressure: none.
// Ports: bitmap (N-bit input), idx (index of highest set bit, 0 if none),
//        any (at least one bit set).
module prio_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] bitmap,
  output logic [W-1:0] idx,
  output logic         any
);

  // Ascending scan: later (higher) set bits overwrite earlier ones.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bitmap[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_dispatch.sv
// Purpose: turn encoded requests into sticky pending bits, grant them one-hot MSB first.
// Latency: in_valid edge T -> pending at T+1 -> out_valid at T+2 when idle.
// Backpressure: each grant is held until ack; at least one idle cycle between grants.
// Ports: clk, rst_n (async active-low), bus (slave modport of prio_dispatch_if).
module prio_dispatch
  import prio_dispatch_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  prio_dispatch_if.slave bus
);

  localparam int W = $clog2(N);

  state_t       state;
  logic [N-1:0] pend_q;
  logic [N-1:0] out_q;
  logic         vld_q;
  logic         ovr_q;

  logic [W-1:0] pick_idx;
  logic         pick_any;
  logic [N-1:0] pick_oh;
  logic [N-1:0] set_mask;
  logic [N-1:0] clr_mask;
  logic         grant_now;
  logic         ovr_set;

  prio_pick #(.N(N)) u_pick (
    .bitmap (pend_q),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    pick_oh = '0;
    pick_oh[pick_idx] = 1'b1;

    // Gate on in_valid so a floating index never touches pending.
    set_mask = '0;
    if (bus.in_valid) begin
      set_mask[bus.in] = 1'b1;
    end

    grant_now = (state == IDLE) && pick_any;
    clr_mask  = grant_now ? pick_oh : '0;

    // A bit being consumed this edge is free to be re-requested without
    // counting as an overrun; the new request is kept as a fresh pending bit.
    ovr_set = |(set_mask & pend_q & ~clr_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend_q <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      // Set is applied after clear so a same-edge set/clear keeps the bit.
      pend_q <= (pend_q & ~clr_mask) | set_mask;

      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (bus.overrun_clr) begin
        ovr_q <= 1'b0;
      end

      // Priority is only evaluated here, on entry to GRANT; new requests
      // during GRANT wait in pending.
      case (state)
        IDLE: begin
          if (grant_now) begin
            out_q <= pick_oh;
            vld_q <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (bus.ack) begin
            out_q <= '0;
            vld_q <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;
  assign bus.pending   = pend_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_prio_dispatch.sv
// Purpose: self-checking bench for prio_dispatch (N=4): per-cycle vector table
//          plus hand-written reset/latency sequences; a grant scoreboard checks
//          the order of granted lines.
module tb_prio_dispatch;

  logic clk;
  logic rst_n;

  prio_dispatch_if #(.N(4)) bus ();

  prio_dispatch #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [1:0] in;
    logic       ack;
    logic       clr;
    logic [3:0] push;   // grant expected later (0 = none)
    logic [3:0] eout;
    logic       evld;
    logic [3:0] epend;
    logic       eovr;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       prev_vld = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eo, input logic ev,
                         input logic [3:0] ep, input logic eov);
    chk({tag, ".out"},       32'(bus.out),       32'(eo));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
    chk({tag, ".pending"},   32'(bus.pending),   32'(ep));
    chk({tag, ".overrun"},   32'(bus.overrun),   32'(eov));
  endtask

  task automatic add(input logic iv, input logic [1:0] in, input logic ack, input logic clr,
                     input logic [3:0] push, input logic [3:0] eout, input logic evld,
                     input logic [3:0] epend, input logic eovr);
    vec_t v;
    v.iv = iv; v.in = in; v.ack = ack; v.clr = clr; v.push = push;
    v.eout = eout; v.evld = evld; v.epend = epend; v.eovr = eovr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [1:0] in, input logic ack, input logic clr);
    bus.in_valid    = iv;
    bus.in          = in;
    bus.ack         = ack;
    bus.overrun_clr = clr;
  endtask

  // Grant monitor: every new grant (out_valid rising) must match the next
  // expected grant in the scoreboard.
  always @(posedge clk) begin
    #2;
    if (bus.out_valid && !prev_vld) begin
      if (sb.size() == 0) begin
        chk("sb.unexpected_grant", 32'(bus.out), 32'h0);
      end else begin
        chk("sb.grant", 32'(bus.out), 32'(sb.pop_front()));
      end
    end
    prev_vld = bus.out_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Columns: iv in ack clr | push | out vld pending ovr
    // Single request, 5-cycle hold, ack, ack ignored in IDLE
    add(1, 2, 0, 0, 4'b0100, 4'b0000, 0, 4'b0100, 0);
    add(0, 0, 0, 0, 4'b0000, 4'b0100, 1, 4'b0000, 0);
    add(0, 0, 0, 0, 4'b0000, 4'b0100, 1, 4'b0000, 0);
    add(0, 0, 0, 0, 4'b0000, 4'b0100, 1, 4'b0000, 0);
    add(0, 0, 0, 0, 4'b0000, 4'b0100, 1, 4'b0000, 0);
    add(0, 0, 0, 0, 4'b0000, 4'b0100, 1, 4'b0000, 0);
    add(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    // Priority order while 0001 is held
    add(1, 0, 0, 0, 4'b0001, 4'b0000, 0, 4'b0001, 0);
    add(0, 0, 0, 0, 4'b0000, 4'b0001, 1, 4'b0000, 0);
    add(1, 1, 0, 0, 4'b1000, 4'b0001, 1, 4'b0010, 0);
    add(1, 3, 0, 0, 4'b0100, 4'b0001, 1, 4'b1010, 0);
    add(1, 2, 0, 0, 4'b0010, 4'b0001, 1, 4'b1110, 0);
    add(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b1110, 0);
    add(0, 0, 0, 0, 4'b0000, 4'b1000, 1, 4'b0110, 0);
    add(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0110, 0);
    add(0, 0, 0, 0, 4'b0000, 4'b0100, 1, 4'b0010, 0);
    add(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0010, 0);
    add(0, 0, 0, 0, 4'b0000, 4'b0010, 1, 4'b0000, 0);
    // Overrun while 1000 is held, single merged grant, clear
    add(1, 3, 1, 0, 4'b1000, 4'b0000, 0, 4'b1000, 0);
    add(0, 0, 0, 0, 4'b0000, 4'b1000, 1, 4'b0000, 0);
    add(1, 2, 0, 0, 4'b0100, 4'b1000, 1, 4'b0100, 0);
    add(1, 2, 0, 0, 4'b0000, 4'b1000, 1, 4'b0100, 1);
    add(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0100, 1);
    add(0, 0, 0, 0, 4'b0000, 4'b0100, 1, 4'b0000, 1);
    add(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 1);
    add(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 1);
    add(0, 0, 0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    // Set wins over grant clear of the same bit
    add(1, 1, 0, 0, 4'b0010, 4'b0000, 0, 4'b0010, 0);
    add(1, 1, 0, 0, 4'b0010, 4'b0010, 1, 4'b0010, 0);
    add(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0010, 0);
    add(0, 0, 0, 0, 4'b0000, 4'b0010, 1, 4'b0000, 0);
    add(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    // Overrun set and clear on the same edge: set wins
    add(1, 0, 0, 0, 4'b0001, 4'b0000, 0, 4'b0001, 0);
    add(0, 0, 0, 0, 4'b0000, 4'b0001, 1, 4'b0000, 0);
    add(1, 3, 0, 0, 4'b1000, 4'b0001, 1, 4'b1000, 0);
    add(1, 3, 0, 1, 4'b0000, 4'b0001, 1, 4'b1000, 1);
    add(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b1000, 1);
    add(0, 0, 0, 1, 4'b0000, 4'b1000, 1, 4'b0000, 0);
    add(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0);

    // Reset held with live-looking inputs and a toggling ack
    rst_n = 1'b0;
    drive(1, 3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.ack = i[0];
      @(posedge clk); #1;
      chk_all($sformatf("reset[%0d]", i), 4'b0000, 0, 4'b0000, 0);
    end
    drive(0, 0, 0, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_all($sformatf("post_reset[%0d]", i), 4'b0000, 0, 4'b0000, 0);
    end

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].in, vecs[i].ack, vecs[i].clr);
      if (vecs[i].push != 4'b0000) sb.push_back(vecs[i].push);
      @(posedge clk); #1;
      chk_all($sformatf("vec[%0d]", i), vecs[i].eout, vecs[i].evld, vecs[i].epend, vecs[i].eovr);
    end

    // Reset mid-grant: out=0100, pending=1001, then asynchronous drop
    drive(1, 2, 0, 0);
    sb.push_back(4'b0100);
    @(posedge clk); #1;
    chk_all("mid.setup0", 4'b0000, 0, 4'b0100, 0);
    drive(1, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("mid.setup1", 4'b0100, 1, 4'b0001, 0);
    drive(1, 3, 0, 0);
    @(posedge clk); #1;
    chk_all("mid.setup2", 4'b0100, 1, 4'b1001, 0);
    drive(0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk_all("mid.async_reset", 4'b0000, 0, 4'b0000, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("mid.after_release", 4'b0000, 0, 4'b0000, 0);

    // Fresh request after reset: T+1 pending, T+2 grant (FSM restarted in IDLE)
    drive(1, 1, 0, 0);
    sb.push_back(4'b0010);
    @(posedge clk); #1;
    chk_all("lat.t1", 4'b0000, 0, 4'b0010, 0);
    drive(0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("lat.t2", 4'b0010, 1, 4'b0000, 0);
    bus.ack = 1'b1;
    @(posedge clk); #1;
    chk_all("lat.ack", 4'b0000, 0, 4'b0000, 0);

    // Unknown index while in_valid=0 must not disturb pending
    bus.ack = 1'b0;
    bus.in  = 'x;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_all($sformatf("xin[%0d]", i), 4'b0000, 0, 4'b0000, 0);
    end
    bus.in = '0;

    @(posedge clk); #3;
    chk("sb.leftover", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
